// File: rtl/accel_mm2s_reader_if.sv
// accel_mm2s_reader_if
//   Bundles the AXI4 read channels (AR/R) and the AXI-Stream output of the
//   MM2S reader into one interface.
//   master : the reader side (drives AR, rready and the stream).
//   slave  : the memory + accelerator side (drives arready, R beats, tready).
//   Signals:
//     araddr/arlen/arvalid/arready        AXI read address channel
//     rdata/rresp/rlast/rvalid/rready     AXI read data channel
//     m_tdata/m_tvalid/m_tlast/m_tready   AXI-Stream toward the accelerator
interface accel_mm2s_reader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready;

    modport master (
        output araddr, arlen, arvalid, rready, m_tdata, m_tvalid, m_tlast,
        input  arready, rdata, rresp, rlast, rvalid, m_tready
    );

    modport slave (
        input  araddr, arlen, arvalid, rready, m_tdata, m_tvalid, m_tlast,
        output arready, rdata, rresp, rlast, rvalid, m_tready
    );
endinterface

// File: rtl/accel_mm2s_reader.sv
// accel_mm2s_reader
//   Memory-to-stream read engine feeding the accelerator input stream.
//   A job of len words starting at src_addr is fetched with AXI4 INCR read
//   bursts, buffered in a FIFO and replayed in order on an AXI-Stream master
//   with m_tlast on the final word.
//   Ports:
//     aclk, aresetn   clock, synchronous active-low reset
//     start           job start pulse, accepted only when idle
//     src_addr, len   job byte address (word aligned internally), word count
//     busy, done, err job status; err is sticky per job
//     stall_cnt       (MM2S_PERF_EN only) cycles stalled by m_tready during a job
//     bus             accel_mm2s_reader_if.master: AR/R channels + stream
//   Optional feature macro: MM2S_PERF_EN adds the stall_cnt counter.
//   Assumes ADDR_WIDTH >= 12 (4 KiB boundary handling).
module accel_mm2s_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef MM2S_PERF_EN
    output logic [31:0]           stall_cnt,
`endif
    accel_mm2s_reader_if.master   bus
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BSH = $clog2(BPW);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(BPW - 1));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  words_req;   // words not yet covered by an AR
    logic [LEN_WIDTH-1:0]  words_out;   // words not yet sent on the stream
    logic                  arvalid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FAW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]         fcnt;
    logic [CW-1:0]         beats_out;   // beats reserved by presented ARs, not yet in FIFO

    // Two-entry queue of in-flight burst lengths so beats can be attributed
    // to bursts without trusting rlast.
    logic [7:0]            bq_len [2];
    logic                  bq_wr, bq_rd;
    logic [1:0]            bursts_out;
    logic [7:0]            r_cnt;

    logic [8:0]  rem9, beats;
    logic [12:0] bnd;
    logic        credit_ok, issue;
    logic        start_ok, r_hs, s_hs, last_hs, ar_hs, bend, m_tvalid;

    logic unused_rlast;
    assign unused_rlast = bus.rlast;

    assign busy     = (state != S_IDLE);
    assign start_ok = start && (state == S_IDLE);
    assign m_tvalid = (fcnt != '0);
    assign r_hs     = bus.rvalid && busy;
    assign s_hs     = m_tvalid && bus.m_tready;
    assign last_hs  = s_hs && (words_out == LEN_WIDTH'(1));
    assign ar_hs    = arvalid_q && bus.arready;
    assign bend     = r_hs && (r_cnt == bq_len[bq_rd]);

    // beats = min(MAX_BURST, words remaining, words to next 4 KiB boundary)
    assign rem9  = (32'(words_req) > 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(words_req);
    assign bnd   = (13'h1000 - {1'b0, next_addr[11:0]}) >> BSH;
    assign beats = (32'(bnd) < 32'(rem9)) ? 9'(bnd) : rem9;
    // Space is reserved at AR presentation, so the FIFO can never overflow.
    assign credit_ok = (32'(fcnt) + 32'(beats_out) + 32'(beats)) <= 32'(FIFO_DEPTH);

    assign bus.arvalid  = arvalid_q;
    assign bus.araddr   = araddr_q;
    assign bus.arlen    = arlen_q;
    assign bus.rready   = busy;
    assign bus.m_tvalid = m_tvalid;
    assign bus.m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
    assign bus.m_tlast  = m_tvalid && (words_out == LEN_WIDTH'(1));

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: if (start && len != '0) state_nxt = S_RUN;
            S_RUN: begin
                issue = (!arvalid_q || bus.arready) && (words_req != '0) &&
                        (bursts_out != 2'd2) && credit_ok;
                if (words_req == '0 && !arvalid_q) state_nxt = S_FLUSH;
                if (last_hs) state_nxt = S_IDLE;
            end
            S_FLUSH: if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            done       <= 1'b0;
            err        <= 1'b0;
            next_addr  <= '0;
            words_req  <= '0;
            words_out  <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fcnt       <= '0;
            beats_out  <= '0;
            bq_len[0]  <= '0;
            bq_len[1]  <= '0;
            bq_wr      <= 1'b0;
            bq_rd      <= 1'b0;
            bursts_out <= '0;
            r_cnt      <= '0;
        end else begin
            done <= (start_ok && len == '0) || last_hs;
            if (start_ok) begin
                err       <= 1'b0;
                next_addr <= src_addr & ADDR_MASK;
                words_req <= len;
                words_out <= len;
            end
            if (r_hs && bus.rresp != 2'b00) err <= 1'b1;

            if (ar_hs) arvalid_q <= 1'b0;
            if (issue) begin
                arvalid_q     <= 1'b1;
                araddr_q      <= next_addr;
                arlen_q       <= 8'(beats - 9'd1);
                next_addr     <= next_addr + ADDR_WIDTH'(32'(beats) * BPW);
                words_req     <= words_req - LEN_WIDTH'(beats);
                bq_len[bq_wr] <= 8'(beats - 9'd1);
                bq_wr         <= ~bq_wr;
            end
            bursts_out <= bursts_out + 2'(issue) - 2'(bend);

            if (r_hs) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (bend) begin
                    r_cnt <= '0;
                    bq_rd <= ~bq_rd;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            if (s_hs) begin
                rd_ptr    <= rd_ptr + 1'b1;
                words_out <= words_out - LEN_WIDTH'(1);
            end
            fcnt      <= fcnt + CW'(r_hs) - CW'(s_hs);
            beats_out <= beats_out + (issue ? CW'(beats) : '0) - CW'(r_hs);
        end
    end

    // FIFO storage needs no reset: emptiness is tracked by fcnt.
    always_ff @(posedge aclk) begin
        if (r_hs) mem[wr_ptr] <= bus.rdata;
    end

`ifdef MM2S_PERF_EN
    always_ff @(posedge aclk) begin
        if (!aresetn)                                              stall_cnt <= '0;
        else if (start_ok)                                         stall_cnt <= '0;
        else if (busy && m_tvalid && !bus.m_tready && stall_cnt != 32'hFFFF_FFFF)
                                                                   stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
